// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back sink; WB_* bus commits GPRs/HI/LO, RDATA1/RDATA2/HI_OUT/LO_OUT are combinational reads with WB bypass
module wb_regfile #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] WB_WDATA,
    input  logic [4:0]        WB_WADDR,
    input  logic              WB_WEN,
    input  logic [DATA_W-1:0] WB_HI,
    input  logic [DATA_W-1:0] WB_LO,
    input  logic              WB_WEN_HILO,
    input  logic              REN1,
    input  logic [4:0]        RADDR1,
    output logic [DATA_W-1:0] RDATA1,
    input  logic              REN2,
    input  logic [4:0]        RADDR2,
    output logic [DATA_W-1:0] RDATA2,
    output logic [DATA_W-1:0] HI_OUT,
    output logic [DATA_W-1:0] LO_OUT
);
    logic [DATA_W-1:0] regs [REG_NUM];
    logic [DATA_W-1:0] hi, lo;
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
            hi <= '0;
            lo <= '0;
        end else begin
            if (WB_WEN && WB_WADDR != 5'd0) regs[WB_WADDR] <= WB_WDATA;
            if (WB_WEN_HILO) begin
                hi <= WB_HI;
                lo <= WB_LO;
            end
        end
    end
    always_comb begin
        RDATA1 = (RST || !REN1 || RADDR1 == 5'd0) ? '0 :
                 (WB_WEN && WB_WADDR == RADDR1) ? WB_WDATA : regs[RADDR1];
        RDATA2 = (RST || !REN2 || RADDR2 == 5'd0) ? '0 :
                 (WB_WEN && WB_WADDR == RADDR2) ? WB_WDATA : regs[RADDR2];
        HI_OUT = RST ? '0 : WB_WEN_HILO ? WB_HI : hi;
        LO_OUT = RST ? '0 : WB_WEN_HILO ? WB_LO : lo;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back sink of the MIPS pipeline: consumes the WB_* bus driven by the MEM/WB pipeline register, and commits results into the 32×32 general-purpose register file and the HI/LO pair. It provides two combinational GPR read ports to the decode stage and a HI/LO read port to execute. Same-cycle write-back data is bypassed to all readers, so a result reaching WB is visible in decode without an extra stall.

## Interface
Parameters:
- REG_NUM, 32, number of GPRs; address width is 5 (`REG_ADDR_BUS`).
- DATA_W, 32, GPR/HI/LO width (`REG_DATA_BUS`).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset; synchronous, active-high (`RST_EN` = 1).
- WB_WDATA  in  32  GPR write data from MEM/WB.
- WB_WADDR  in  5  GPR write address.
- WB_WEN  in  1  GPR write enable (`WENABLE` = 1).
- WB_HI  in  32  HI write data.
- WB_LO  in  32  LO write data.
- WB_WEN_HILO  in  1  HI and LO write enable; both are written together.
- REN1  in  1  read-port-1 enable.
- RADDR1  in  5  read-port-1 address.
- RDATA1  out  32  read-port-1 data; combinational.
- REN2  in  1  read-port-2 enable.
- RADDR2  in  5  read-port-2 address.
- RDATA2  out  32  read-port-2 data; combinational.
- HI_OUT  out  32  current HI, with WB bypass; combinational.
- LO_OUT  out  32  current LO, with WB bypass; combinational.

## Operation
- GPR write: on posedge, if RST low, WB_WEN = 1 and WB_WADDR ≠ 0, then regs[WB_WADDR] <= WB_WDATA.
- $0 is hardwired to zero. Writes to address 0 are discarded.
- HI/LO write: on posedge, if RST low and WB_WEN_HILO = 1, then HI <= WB_HI and LO <= WB_LO.
- A bubble from MEM/WB (WEN = 0, WEN_HILO = 0, address and data zero) causes no state change.
- Read port n is evaluated in priority order:
  1. RST = 1 gives 0.
  2. RENn = 0 gives 0.
  3. RADDRn = 0 gives 0.
  4. WB_WEN = 1 and WB_WADDR == RADDRn gives WB_WDATA (bypass).
  5. Otherwise, regs[RADDRn].
- HI_OUT/LO_OUT evaluation:
  - RST = 1 gives 0.
  - WB_WEN_HILO = 1 gives WB_HI/WB_LO (bypass).
  - Otherwise, the stored HI/LO.
- Both read ports are independent. They may address the same register; both then return the same value, including when it comes from the bypass.
- The GPR write and the HI/LO write in the same cycle are independent and both commit.

## Timing
- Reset:
  - While RST = 1 at a posedge, all 32 GPRs, HI and LO are cleared to 0 (`ZERO_WORD`), and any write presented that cycle is ignored.
  - All outputs read 0 while RST = 1.
  - If RST rises mid-stream, the in-flight WB write in that cycle is lost.
- Write latency: data is committed at the posedge following its presentation. It appears at RDATA via the bypass in the same cycle it is presented, and from storage in every later cycle.
- Read latency: 0 cycles; RDATA, HI_OUT and LO_OUT are purely combinational from the inputs and stored state.
- No handshake. WB is always ready; the producer's STALL handling guarantees each valid WB word is held for exactly one cycle, or repeated harmlessly.
- A repeated identical write over several cycles (WB frozen by stall) is idempotent.
- The block asserts no back-pressure on the pipeline.

## Test plan
- Reset clear: preload r5 = 0x12345678 and HI = 0xAAAA0000. Assert RST for 1 cycle, then read r5 and HI_OUT. Required: both read 0, and both read 0 during the reset cycle too.
- Write then read: WB_WEN = 1, WADDR = 3, WDATA = 0xDEADBEEF for 1 cycle, then WEN = 0. Read RADDR1 = 3 and RADDR2 = 3 with REN = 1. Required: 0xDEADBEEF on both ports, in the write cycle (bypass) and in every following cycle.
- $0 protection: write WADDR = 0, WDATA = 0xFFFFFFFF with WEN = 1, and read RADDR1 = 0 in the same and next cycle. Required: RDATA1 = 0 in both cycles.
- Bypass priority over stale value: r7 = 0x1, then present WEN = 1, WADDR = 7, WDATA = 0x2. Required: RDATA1 (addr 7) = 0x2 in that cycle. With REN1 = 0 in that same cycle, RDATA1 = 0.
- HI/LO path: WB_WEN_HILO = 1, WB_HI = 0x0000_0001, WB_LO = 0xFFFF_FFFE. Required: HI_OUT and LO_OUT show these values in the same cycle and after the edge. In the same cycle, WB_WEN = 1, WADDR = 9, WDATA = 0x55 must also commit, so r9 = 0x55.
- Bubble and idempotence:
  - Hold WEN = 1, WADDR = 4, WDATA = 0x77 for 3 cycles (stalled WB). Required: r4 = 0x77.
  - Then apply a zero bubble (all enables 0) for 2 cycles. Required: r4 and HI/LO remain unchanged.
